// File: rtl/uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_packer
// Description : Packs bytes from a UART receiver into 32-bit little-endian
//               words and buffers them in a small word FIFO.
//               accept_i / rece_data_i come from the slower BPS domain and are
//               resynchronised with 2-flop synchronizers. A byte event is the
//               rising edge of the synchronised accept. Every fourth byte
//               completes a word, which is pushed into the FIFO one cycle
//               later. A push into a full FIFO with no simultaneous pop drops
//               the word and sets the sticky overflow_o flag.
//               Optional build macro UART_PACKER_TIMEOUT_EN: a partial word
//               left idle for TIMEOUT_CYCLES clk_i cycles is discarded.
// Ports       : clk_i         system clock, rising edge
//               rst_i         asynchronous reset, active low
//               rece_data_i   received byte (BPS domain)
//               accept_i      byte-complete flag (BPS domain)
//               word_o        FIFO head word, 0 when the FIFO is empty
//               word_valid_o  FIFO non-empty
//               word_ready_i  consumer accepts word_o when word_valid_o high
//               byte_cnt_o    bytes held in the partial word
//               fifo_count_o  words stored, 0..FIFO_DEPTH
//               overflow_o    sticky: a completed word was dropped
//               clear_i       synchronous flush of partial word, FIFO, flag
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_packer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [7:0]                  rece_data_i,
  input  logic                        accept_i,
  output logic [31:0]                 word_o,
  output logic                        word_valid_o,
  input  logic                        word_ready_i,
  output logic [1:0]                  byte_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        overflow_o,
  input  logic                        clear_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

  // Synchronizers and edge detector
  logic       acc_meta_q, acc_sync_q, acc_prev_q;
  logic [7:0] data_meta_q, data_sync_q;
  logic       byte_evt;

  // Word assembly
  logic [1:0]  byte_cnt_q,  byte_cnt_d;
  logic [23:0] lanes_q,     lanes_d;      // bytes 0..2 of the word in progress
  logic        push_q,      push_d;
  logic [31:0] push_word_q, push_word_d;

  // Word FIFO
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             overflow_q, overflow_d;
  logic             pop, room, wr_en;

`ifdef UART_PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`else
  // No idle counter in this build; the parameter only exists so both builds
  // share one interface. This empty block is never elaborated for sane values.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // --------------------------------------------------------------------------
  // Clock-domain crossing: the receiver holds data stable while accept is
  // high, so data and accept synchronised in parallel line up at the edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_meta_q  <= 1'b0;
      acc_sync_q  <= 1'b0;
      acc_prev_q  <= 1'b0;
      data_meta_q <= 8'h00;
      data_sync_q <= 8'h00;
    end else begin
      acc_meta_q  <= accept_i;
      acc_sync_q  <= acc_meta_q;
      acc_prev_q  <= acc_sync_q;
      data_meta_q <= rece_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign byte_evt = acc_sync_q & ~acc_prev_q;

  // A pop needs a non-empty FIFO; a push succeeds when there is room or the
  // same cycle frees an entry. clear_i suppresses both.
  assign pop   = (count_q != '0) && word_ready_i && !clear_i;
  assign room  = (count_q != C_DEPTH) || pop;
  assign wr_en = push_q && room && !clear_i;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    lanes_d     = lanes_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
`ifdef UART_PACKER_TIMEOUT_EN
    idle_d      = idle_q;
`endif

    if (clear_i) begin
      byte_cnt_d = 2'd0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
`ifdef UART_PACKER_TIMEOUT_EN
      idle_d     = '0;
`endif
    end else begin
      if (byte_evt) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    lanes_d[7:0]   = data_sync_q;
          2'd1:    lanes_d[15:8]  = data_sync_q;
          2'd2:    lanes_d[23:16] = data_sync_q;
          default: begin
            // Fourth byte goes straight into the staged word.
            push_d      = 1'b1;
            push_word_d = {data_sync_q, lanes_q};
          end
        endcase
`ifdef UART_PACKER_TIMEOUT_EN
        idle_d = '0;
      end else if (byte_cnt_q != 2'd0) begin
        if (idle_q == C_IDLE_LAST) begin
          byte_cnt_d = 2'd0;
          idle_d     = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end else begin
        idle_d = '0;
`endif
      end

      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (push_q && !room) begin
        overflow_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_cnt_q  <= 2'd0;
      lanes_q     <= 24'h0;
      push_q      <= 1'b0;
      push_word_q <= 32'h0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
`ifdef UART_PACKER_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      lanes_q     <= lanes_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
`ifdef UART_PACKER_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= push_word_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign word_valid_o = (count_q != '0);
  assign word_o       = word_valid_o ? mem_q[rd_ptr_q] : 32'h0;
  assign byte_cnt_o   = byte_cnt_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_packer
// Description : Self-checking bench for uart_word_packer. Stimulus emulates a
//               UART receiver (accept pulse of several clk cycles with stable
//               data). A reference model groups bytes into words, tracks FIFO
//               occupancy and overflow, and queues expected words; a monitor
//               compares every word the DUT hands over against that queue.
//               Build with UART_PACKER_TIMEOUT_EN to check the timeout build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_packer;

  localparam int TIMEOUT = 1024;
  localparam int DEPTH   = 4;
  localparam int GAP     = 10;   // clk cycles per byte slot

  logic        clk = 1'b0;
  logic        rst_i, accept_i, word_ready_i, clear_i;
  logic [7:0]  rece_data_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic [1:0]  byte_cnt_o;
  logic [2:0]  fifo_count_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  uart_word_packer #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rece_data_i  (rece_data_i),
    .accept_i     (accept_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .byte_cnt_o   (byte_cnt_o),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o),
    .clear_i      (clear_i)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];     // words expected from the DUT, oldest first
  logic [7:0]  part  [$];     // bytes of the word in progress
  logic        exp_ovf;
  bit          rnd_ready = 1'b0;
  int          valid_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must deliver the oldest expected word.
  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      if (word_valid_o) valid_cycles++;
      if (word_valid_o && word_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %h expected no word", word_o);
        end else begin
          chk("pop_word", word_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) word_ready_i = 1'($urandom_range(0, 1));
  endtask

  // Reference model: four bytes form a little-endian word; a word arriving at
  // a full FIFO that is not being read at that moment is lost.
  task automatic model_byte(input logic [7:0] b, input bit pop_at_push);
    logic [31:0] w;
    part.push_back(b);
    if (part.size() == 4) begin
      w = {part[3], part[2], part[1], part[0]};
      part.delete();
      if (exp_q.size() >= DEPTH && !pop_at_push && !word_ready_i) exp_ovf = 1'b1;
      else exp_q.push_back(w);
    end
  endtask

  // One UART byte: accept high for 4 clk cycles. With pop_at_push the
  // consumer is ready for exactly the cycle the completed word is pushed.
  task automatic send_byte(input logic [7:0] b, input bit pop_at_push = 1'b0);
    model_byte(b, pop_at_push);
    tick();
    accept_i    = 1'b1;
    rece_data_i = b;
    for (int i = 1; i <= GAP; i++) begin
      tick();
      if (i == 3 && pop_at_push) word_ready_i = 1'b1;
      if (i == 4) begin
        accept_i = 1'b0;
        if (pop_at_push) word_ready_i = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
`ifdef UART_PACKER_TIMEOUT_EN
    if (n >= TIMEOUT) part.delete();
`endif
  endtask

  task automatic drain();
    word_ready_i = 1'b1;
    repeat (8) tick();
    chk("drain_fifo_count", 32'(fifo_count_o), 32'd0);
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(word_valid_o), 32'd0);
    chk("drain_word_zero", word_o, 32'h0);
  endtask

  task automatic do_clear();
    tick();
    clear_i = 1'b1;
    part.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i        = 1'b0;
    accept_i     = 1'b0;
    rece_data_i  = 8'h00;
    word_ready_i = 1'b0;
    clear_i      = 1'b0;
    exp_ovf      = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", word_o, 32'h0);
    chk("rst_valid", 32'(word_valid_o), 32'd0);
    chk("rst_byte_cnt", 32'(byte_cnt_o), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    rst_i = 1'b1;
    tick(); tick();

    // Single word, consumer always ready: valid for exactly one cycle
    word_ready_i = 1'b1;
    valid_cycles = 0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(5);
    chk("single_valid_cycles", 32'(valid_cycles), 32'd1);
    chk("single_fifo_count", 32'(fifo_count_o), 32'd0);
    chk("single_model_empty", 32'(exp_q.size()), 32'd0);

    // Random bytes with a randomly stalling consumer
    rnd_ready = 1'b1;
    repeat (40) send_byte(8'($urandom));
    rnd_ready = 1'b0;
    drain();
    chk("random_overflow", 32'(overflow_o), 32'd0);

    // 20 bytes into a stalled consumer: four words kept, the fifth dropped
    word_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    chk("ovf_fifo_count", 32'(fifo_count_o), 32'd4);
    chk("ovf_flag", 32'(overflow_o), 32'(exp_ovf));
    chk("ovf_flag_set", 32'(overflow_o), 32'd1);
    chk("ovf_byte_cnt", 32'(byte_cnt_o), 32'd0);
    chk("ovf_head", word_o, 32'h03020100);
    drain();
    chk("ovf_sticky", 32'(overflow_o), 32'd1);
    do_clear();
    chk("ovf_cleared", 32'(overflow_o), 32'd0);

    // Full FIFO, word completes in the cycle the consumer takes one
    word_ready_i = 1'b0;
    repeat (16) send_byte(8'($urandom));
    chk("full_fifo_count", 32'(fifo_count_o), 32'd4);
    repeat (3) send_byte(8'($urandom));
    send_byte(8'($urandom), 1'b1);
    chk("pushpop_fifo_count", 32'(fifo_count_o), 32'd4);
    chk("pushpop_overflow", 32'(overflow_o), 32'd0);
    drain();

    // Reset in the middle of a word with a word still stored
    word_ready_i = 1'b0;
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    send_byte(8'hAA); send_byte(8'hBB);
    chk("prerst_byte_cnt", 32'(byte_cnt_o), 32'd2);
    chk("prerst_fifo_count", 32'(fifo_count_o), 32'd1);
    rst_i = 1'b0;
    #2;
    chk("midrst_byte_cnt", 32'(byte_cnt_o), 32'd0);
    chk("midrst_fifo_count", 32'(fifo_count_o), 32'd0);
    chk("midrst_valid", 32'(word_valid_o), 32'd0);
    chk("midrst_word", word_o, 32'h0);
    exp_q.delete();
    part.delete();
    exp_ovf = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    chk("postrst_word", word_o, 32'h04030201);
    chk("postrst_fifo_count", 32'(fifo_count_o), 32'd1);
    drain();

    // Lone byte followed by a long idle period
    word_ready_i = 1'b0;
    send_byte(8'hAA);
    idle(1100);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
`ifdef UART_PACKER_TIMEOUT_EN
    chk("idle_word", word_o, 32'h04030201);
    chk("idle_byte_cnt", 32'(byte_cnt_o), 32'd0);
`else
    chk("idle_word", word_o, 32'h030201AA);
    chk("idle_byte_cnt", 32'(byte_cnt_o), 32'd1);
`endif
    chk("idle_fifo_count", 32'(fifo_count_o), 32'd1);
    drain();
    do_clear();
    chk("idle_clear_byte_cnt", 32'(byte_cnt_o), 32'd0);

    // Clear with FIFO=2, byte_cnt=3, overflow set
    word_ready_i = 1'b0;
    repeat (24) send_byte(8'($urandom));
    word_ready_i = 1'b1;
    tick(); tick();
    word_ready_i = 1'b0;
    repeat (3) send_byte(8'($urandom));
    chk("preclr_fifo_count", 32'(fifo_count_o), 32'd2);
    chk("preclr_byte_cnt", 32'(byte_cnt_o), 32'd3);
    chk("preclr_overflow", 32'(overflow_o), 32'd1);
    do_clear();
    chk("clr_fifo_count", 32'(fifo_count_o), 32'd0);
    chk("clr_byte_cnt", 32'(byte_cnt_o), 32'd0);
    chk("clr_overflow", 32'(overflow_o), 32'd0);
    chk("clr_valid", 32'(word_valid_o), 32'd0);
    chk("clr_word", word_o, 32'h0);

    // Normal operation after the clear
    word_ready_i = 1'b1;
    send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hC3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_word_packer.md
UART_WORD_PACKER -- requirements
Module: uart_word_packer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: idle clk_i cycles after which a partial word is discarded (timeout build only).
REQ-002 Parameter FIFO_DEPTH, default 4: word FIFO entries, fixed power of two.
REQ-003 clk_i  input  1  single system clock, all logic on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 rece_data_i  input  8  received byte from UART receiver (clk_BPS_i domain).
REQ-006 accept_i  input  1  byte-complete flag from UART receiver, high for one BPS period.
REQ-007 word_o  output  32  FIFO head word, little-endian (first byte in [7:0]).
REQ-008 word_valid_o  output  1  FIFO non-empty.
REQ-009 word_ready_i  input  1  consumer accepts word_o when word_valid_o high.
REQ-010 byte_cnt_o  output  2  bytes held in the partial word.
REQ-011 fifo_count_o  output  3  words stored, 0..FIFO_DEPTH.
REQ-012 overflow_o  output  1  sticky: a completed word was dropped.
REQ-013 clear_i  input  1  synchronous: flush partial word, FIFO, and overflow_o.

Function
REQ-014 accept_i and rece_data_i SHALL each pass through a 2-flop synchronizer; a byte event is the cycle synced accept goes 0->1.
REQ-015 On a byte event, the synced rece_data_i SHALL be written to byte lane byte_cnt_o and byte_cnt_o incremented mod 4.
REQ-016 Supported clock ratio: clk_i >= 4x BPS clock; a single accept pulse SHALL produce exactly one byte event.
REQ-017 On the byte event making byte_cnt_o wrap 3->0, the assembled word SHALL be pushed to the FIFO in the next cycle; total latency synced edge -> word_valid_o high = 2 clk_i cycles with FIFO previously empty.
REQ-018 Pop SHALL occur on any cycle with word_valid_o && word_ready_i; word_o SHALL show the next entry the following cycle.
REQ-019 Push with FIFO full and no pop in the same cycle SHALL drop the word, set overflow_o, and leave FIFO contents unchanged.
REQ-020 Push and pop in the same cycle SHALL both succeed even when full; fifo_count_o unchanged.
REQ-021 Pop with FIFO empty SHALL be ignored.
REQ-022 Read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap silently; fifo_count_o disambiguates full/empty.
REQ-023 overflow_o SHALL stay high until clear_i or reset.
REQ-024 clear_i SHALL take priority over a simultaneous byte event, push, or pop; all are discarded.
REQ-025 word_o SHALL be 0 when FIFO empty.

Reset
REQ-026 Asserting rst_i low SHALL immediately force: synchronizers 0, byte_cnt_o 0, fifo_count_o 0, word_valid_o 0, word_o 0, overflow_o 0, pointers 0.
REQ-027 Reset mid-word or mid-FIFO SHALL discard all stored data; no byte event SHALL be generated on the first cycle after release, even if accept_i is high.

Configuration
REQ-028 Macro UART_PACKER_TIMEOUT_EN defined: an idle counter SHALL count clk_i cycles while byte_cnt_o != 0 with no byte event, reset on every byte event, and on reaching TIMEOUT_CYCLES SHALL clear byte_cnt_o to 0 (partial bytes discarded, FIFO untouched).
REQ-029 Macro UART_PACKER_TIMEOUT_EN undefined: no idle counter; a partial word SHALL be held indefinitely until completed, clear_i, or reset.

Verification
REQ-030 Bytes 0x11,0x22,0x33,0x44, word_ready_i=1 -> word_o=0x44332211, word_valid_o high one cycle, fifo_count_o returns to 0.
REQ-031 20 bytes 0x00..0x13, word_ready_i=0 -> fifo_count_o=4, overflow_o=1, pop order 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
REQ-032 FIFO full, word completes while word_ready_i=1 -> fifo_count_o stays 4, overflow_o stays 0.
REQ-033 Two bytes 0xAA,0xBB then rst_i low mid-stream, then bytes 0x01..0x04 -> word_o=0x04030201.
REQ-034 Timeout build, TIMEOUT_CYCLES=1024: byte 0xAA, idle 1100 cycles, bytes 0x01..0x04 -> word_o=0x04030201; non-timeout build same stimulus -> word_o=0x030201AA, byte_cnt_o=1.
REQ-035 clear_i pulsed with fifo_count_o=2, byte_cnt_o=3, overflow_o=1 -> all read 0 next cycle, word_valid_o=0.
